seq_divider_iter: RTL and testbench

//  Iterative restoring unsigned divider. It is the inverse-direction companion to the

---
 rtl/seq_divider_iter.sv | 113 +++++++++++
 tb/tb_seq_divider_iter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_divider_iter.sv
// Iterative restoring unsigned divider: one quotient bit per clock, valid/ready on both sides.
// A zero divisor skips the iteration and returns all-ones with the dividend's low bits.
module seq_divider_iter #(
    parameter int DW = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder,
    output logic          div_zero
);

    // state | meaning
    // IDLE  | waiting for an operation; in_ready high one cycle after entry
    // CALC  | shifting in one quotient bit per cycle, DW cycles total
    // DONE  | result held on the outputs until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_t        state;
    logic [SW:0]   r_work;
    logic [DW-1:0] q_work;
    logic [SW-1:0] div_reg;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          release_ok;
    logic [SW:0]   t_val;
    logic [SW:0]   r_next;
    logic [DW-1:0] q_next;
    logic          ge;

    assign accept     = in_valid & in_ready;
    assign release_ok = out_valid & out_ready;

    // One extra bit on the partial remainder keeps the compare and subtract overflow-free.
    assign t_val  = {r_work[SW-1:0], q_work[DW-1]};
    assign ge     = (t_val >= {1'b0, div_reg});
    assign r_next = ge ? (t_val - {1'b0, div_reg}) : t_val;
    assign q_next = {q_work[DW-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            r_work    <= '0;
            q_work    <= '0;
            div_reg   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // in_ready lags IDLE entry by a cycle, so no release+accept overlap.
                    in_ready <= ~accept;
                    if (accept) begin
                        if (divisor != '0) begin
                            state    <= S_CALC;
                            r_work   <= '0;
                            q_work   <= dividend;
                            div_reg  <= divisor;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            quotient  <= '1;
                            remainder <= dividend[SW-1:0];
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    in_ready <= 1'b0;
                    r_work   <= r_next;
                    q_work   <= q_next;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= S_DONE;
                        quotient  <= q_next;
                        remainder <= r_next[SW-1:0];
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    in_ready <= 1'b0;
                    if (release_ok) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_iter.sv
// Directed and randomized checks of seq_divider_iter at DW=8, SW=4.
module tb_seq_divider_iter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider_iter #(.DW(8), .SW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Issue one op, check latency and result, stall `stall` cycles, then release.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int stall,
                          input logic [7:0] eq, input logic [3:0] er, input logic ez,
                          input string tag);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = 8'($urandom);
        divisor   = 4'($urandom);
        out_ready = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                out_ready = 1'($urandom);
                in_valid  = 1'($urandom);
            end
        end while (!out_valid && lat < 30);
        out_ready = (stall == 0);
        in_valid  = 1'b0;
        check({tag, "_lat"}, lat, (b == 4'd0) ? 32'd1 : 32'd9);
        check({tag, "_q"}, {24'b0, quotient}, {24'b0, eq});
        check({tag, "_r"}, {28'b0, remainder}, {28'b0, er});
        check({tag, "_dz"}, {31'b0, div_zero}, {31'b0, ez});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(negedge clk);
            check({tag, "_stall_ov"}, {31'b0, out_valid}, 32'd1);
            check({tag, "_stall_rdy"}, {31'b0, in_ready}, 32'd0);
            check({tag, "_stall_qr"}, {19'b0, quotient, remainder, div_zero},
                  {19'b0, eq, er, ez});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_rdy_lag"}, {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_rdy_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] b;
        logic       saw_ov;

        #23;
        check("rst_rdy", {31'b0, in_ready}, 32'd0);
        check("rst_ov", {31'b0, out_valid}, 32'd0);
        check("rst_q", {24'b0, quotient}, 32'd0);
        check("rst_r", {28'b0, remainder}, 32'd0);
        check("rst_dz", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy_up", {31'b0, in_ready}, 32'd1);

        run_op(8'd200, 4'd7, 0, 8'd28, 4'd4, 1'b0, "d200_7");
        run_op(8'd255, 4'd15, 0, 8'd17, 4'd0, 1'b0, "d255_15");
        run_op(8'd5, 4'd9, 0, 8'd0, 4'd5, 1'b0, "d5_9");
        run_op(8'd0, 4'd1, 0, 8'd0, 4'd0, 1'b0, "d0_1");
        run_op(8'd255, 4'd1, 0, 8'd255, 4'd0, 1'b0, "d255_1");
        run_op(8'd13, 4'd0, 0, 8'hFF, 4'hD, 1'b1, "d13_0");
        run_op(8'd12, 4'd3, 0, 8'd4, 4'd0, 1'b0, "d12_3");
        run_op(8'd100, 4'd3, 6, 8'd33, 4'd1, 1'b0, "bp100_3");

        // Reset during CALC discards the op.
        in_valid = 1'b1;
        dividend = 8'd77;
        divisor  = 4'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", {31'b0, out_valid}, 32'd0);
        check("mid_rst_rdy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_ov = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_ov = 1'b1;
        end
        check("mid_rst_no_ov", {31'b0, saw_ov}, 32'd0);
        run_op(8'd100, 4'd10, 0, 8'd10, 4'd0, 1'b0, "d100_10");

        for (int k = 0; k < 2000; k++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            if (b == 4'd0)
                run_op(a, b, int'($urandom_range(0, 3)), 8'hFF, a[3:0], 1'b1, "rnd");
            else
                run_op(a, b, int'($urandom_range(0, 3)), 8'(a / b), 4'(a % b), 1'b0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
